// File: rtl/tft_power_sequencer.sv
// -----------------------------------------------------------------------------
// tft_power_sequencer
//
// Power-up / power-down sequencer for a TFT panel: VDD first, then display
// enable, then a frame-paced backlight ramp; the reverse on power-down.
// Also latches touch samples and releases them to the outputs only on frame
// boundaries so the rest of the system never sees a coordinate change
// mid-frame.
//
// Ports
//   tft_clk            sole clock, rising edge
//   rstb               asynchronous active-low reset
//   power_req          level, 1 = panel should be on
//   target_duty[7:0]   requested backlight duty
//   new_frame          frame marker from the TFT timing generator
//   touch_valid        one-cycle strobe qualifying touch_x_in/touch_y_in
//   touch_x_in[11:0]   raw touch X
//   touch_y_in[11:0]   raw touch Y
//   tft_vdd_en         panel VDD enable
//   tft_display_en     panel display enable
//   duty_cycle[7:0]    backlight PWM duty
//   frequency_division backlight PWM divider (constant PWM_DIV)
//   touch_x[11:0]      frame-aligned, clamped touch X
//   touch_y[11:0]      frame-aligned, clamped touch Y
//   ready              panel fully on (RUN)
//   state[2:0]         current sequencer state code
// -----------------------------------------------------------------------------
module tft_power_sequencer #(
  parameter logic [15:0] VDD_WAIT    = 16'd1000,
  parameter logic [3:0]  DISP_FRAMES = 4'd4,
  parameter logic [7:0]  RAMP_STEP   = 8'd8,
  parameter logic [31:0] PWM_DIV     = 32'd1000
) (
  input  logic        tft_clk,
  input  logic        rstb,
  input  logic        power_req,
  input  logic [7:0]  target_duty,
  input  logic        new_frame,
  input  logic        touch_valid,
  input  logic [11:0] touch_x_in,
  input  logic [11:0] touch_y_in,
  output logic        tft_vdd_en,
  output logic        tft_display_en,
  output logic [7:0]  duty_cycle,
  output logic [31:0] frequency_division,
  output logic [11:0] touch_x,
  output logic [11:0] touch_y,
  output logic        ready,
  output logic [2:0]  state
);

  localparam logic [2:0] ST_OFF       = 3'b000;
  localparam logic [2:0] ST_VDD_UP    = 3'b001;
  localparam logic [2:0] ST_DISP_UP   = 3'b010;
  localparam logic [2:0] ST_RAMP_UP   = 3'b011;
  localparam logic [2:0] ST_RUN       = 3'b100;
  localparam logic [2:0] ST_RAMP_DOWN = 3'b101;
  localparam logic [2:0] ST_DISP_DOWN = 3'b110;

  localparam logic [11:0] X_MAX   = 12'd479;
  localparam logic [11:0] Y_MAX   = 12'd271;
  localparam logic [11:0] X_RESET = 12'd240;
  localparam logic [11:0] Y_RESET = 12'd136;

  // Upward step limited to the target; the sum is formed in 9 bits so a
  // duty near 255 saturates at the target instead of wrapping.
  function automatic logic [7:0] ramp_up_duty(input logic [7:0] d, input logic [7:0] t);
    logic [8:0] sum;
    sum = {1'b0, d} + {1'b0, RAMP_STEP};
    return (sum > {1'b0, t}) ? t : sum[7:0];
  endfunction

  // Downward step saturating at zero.
  function automatic logic [7:0] ramp_down_duty(input logic [7:0] d);
    return (d > RAMP_STEP) ? (d - RAMP_STEP) : 8'd0;
  endfunction

  // Bidirectional move toward the target, never overshooting it.
  function automatic logic [7:0] toward_duty(input logic [7:0] d, input logic [7:0] t);
    logic [7:0] diff;
    diff = 8'd0;
    if (d < t) begin
      return ramp_up_duty(d, t);
    end else if (d > t) begin
      diff = d - t;
      return (diff > RAMP_STEP) ? (d - RAMP_STEP) : t;
    end
    return d;
  endfunction

  function automatic logic [11:0] clamp_coord(input logic [11:0] v, input logic [11:0] lim);
    return (v > lim) ? lim : v;
  endfunction

  logic        frame_prev;
  logic        frame_tick;
  logic [15:0] cnt;
  logic [15:0] cnt_nx;
  logic [3:0]  fcnt;
  logic [3:0]  fcnt_nx;
  logic [2:0]  state_nx;
  logic [7:0]  duty_nx;
  logic [11:0] shadow_x;
  logic [11:0] shadow_y;
  logic        pending;

  assign frame_tick         = new_frame & ~frame_prev;
  assign frequency_division = PWM_DIV;

  // Wait counters transition on the cycle the count would reach zero, so
  // each timed state lasts exactly VDD_WAIT cycles (and DISP_FRAMES ticks).
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    fcnt_nx  = fcnt;
    duty_nx  = duty_cycle;
    case (state)
      ST_OFF: begin
        duty_nx = 8'd0;
        if (power_req) begin
          state_nx = ST_VDD_UP;
          cnt_nx   = VDD_WAIT;
        end
      end
      ST_VDD_UP: begin
        duty_nx = 8'd0;
        if (!power_req) begin
          state_nx = ST_OFF;
          cnt_nx   = 16'd0;
        end else if (cnt <= 16'd1) begin
          state_nx = ST_DISP_UP;
          cnt_nx   = 16'd0;
          fcnt_nx  = DISP_FRAMES;
        end else begin
          cnt_nx = cnt - 16'd1;
        end
      end
      ST_DISP_UP: begin
        duty_nx = 8'd0;
        if (!power_req) begin
          state_nx = ST_DISP_DOWN;
          cnt_nx   = VDD_WAIT;
          fcnt_nx  = 4'd0;
        end else if (fcnt == 4'd0 || (frame_tick && fcnt == 4'd1)) begin
          state_nx = ST_RAMP_UP;
          fcnt_nx  = 4'd0;
        end else if (frame_tick) begin
          fcnt_nx = fcnt - 4'd1;
        end
      end
      ST_RAMP_UP: begin
        if (!power_req) begin
          state_nx = ST_RAMP_DOWN;
        end else if (duty_cycle == target_duty) begin
          state_nx = ST_RUN;
        end else if (frame_tick) begin
          duty_nx = ramp_up_duty(duty_cycle, target_duty);
        end
      end
      ST_RUN: begin
        if (!power_req) begin
          state_nx = ST_RAMP_DOWN;
        end else if (frame_tick) begin
          duty_nx = toward_duty(duty_cycle, target_duty);
        end
      end
      ST_RAMP_DOWN: begin
        if (power_req) begin
          state_nx = ST_RAMP_UP;
        end else if (duty_cycle == 8'd0) begin
          state_nx = ST_DISP_DOWN;
          cnt_nx   = VDD_WAIT;
        end else if (frame_tick) begin
          duty_nx = ramp_down_duty(duty_cycle);
        end
      end
      ST_DISP_DOWN: begin
        duty_nx = 8'd0;
        if (cnt <= 16'd1) begin
          state_nx = ST_OFF;
          cnt_nx   = 16'd0;
        end else begin
          cnt_nx = cnt - 16'd1;
        end
      end
      default: begin
        state_nx = ST_OFF;
        cnt_nx   = 16'd0;
        fcnt_nx  = 4'd0;
        duty_nx  = 8'd0;
      end
    endcase
  end

  // Enables and ready are decoded from the next state and registered so
  // they change on the same edge as the state code.
  always_ff @(posedge tft_clk or negedge rstb) begin
    if (!rstb) begin
      state          <= ST_OFF;
      cnt            <= 16'd0;
      fcnt           <= 4'd0;
      duty_cycle     <= 8'd0;
      tft_vdd_en     <= 1'b0;
      tft_display_en <= 1'b0;
      ready          <= 1'b0;
      frame_prev     <= 1'b0;
    end else begin
      state          <= state_nx;
      cnt            <= cnt_nx;
      fcnt           <= fcnt_nx;
      duty_cycle     <= duty_nx;
      tft_vdd_en     <= (state_nx != ST_OFF);
      tft_display_en <= (state_nx == ST_DISP_UP) || (state_nx == ST_RAMP_UP) ||
                        (state_nx == ST_RUN)     || (state_nx == ST_RAMP_DOWN);
      ready          <= (state_nx == ST_RUN);
      frame_prev     <= new_frame;
    end
  end

  // Touch path: the outputs take the old shadow on a tick while a
  // coincident strobe reloads the shadow and keeps the sample pending.
  always_ff @(posedge tft_clk or negedge rstb) begin
    if (!rstb) begin
      shadow_x <= X_RESET;
      shadow_y <= Y_RESET;
      pending  <= 1'b0;
      touch_x  <= X_RESET;
      touch_y  <= Y_RESET;
    end else begin
      if (frame_tick && pending) begin
        touch_x <= shadow_x;
        touch_y <= shadow_y;
        pending <= 1'b0;
      end
      if (touch_valid) begin
        shadow_x <= clamp_coord(touch_x_in, X_MAX);
        shadow_y <= clamp_coord(touch_y_in, Y_MAX);
        pending  <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_tft_power_sequencer.sv
// -----------------------------------------------------------------------------
// tb_tft_power_sequencer
//
// Directed scenarios (power-up, saturation, abort, touch alignment, async
// reset, direction change) followed by a randomized run, all compared every
// cycle against a behavioural model of the sequencing rules.
// -----------------------------------------------------------------------------
module tb_tft_power_sequencer;

  localparam int VW = 4;
  localparam int DF = 2;
  localparam int RS = 8;
  localparam int PD = 1000;

  localparam int S_OFF = 0, S_VDD_UP = 1, S_DISP_UP = 2, S_RAMP_UP = 3,
                 S_RUN = 4, S_RAMP_DOWN = 5, S_DISP_DOWN = 6;

  logic        tft_clk = 1'b0;
  logic        rstb = 1'b0;
  logic        power_req = 1'b0;
  logic [7:0]  target_duty = 8'd0;
  logic        new_frame = 1'b0;
  logic        touch_valid = 1'b0;
  logic [11:0] touch_x_in = 12'd0;
  logic [11:0] touch_y_in = 12'd0;
  logic        tft_vdd_en;
  logic        tft_display_en;
  logic [7:0]  duty_cycle;
  logic [31:0] frequency_division;
  logic [11:0] touch_x;
  logic [11:0] touch_y;
  logic        ready;
  logic [2:0]  state;

  tft_power_sequencer #(
    .VDD_WAIT   (16'd4),
    .DISP_FRAMES(4'd2),
    .RAMP_STEP  (8'd8),
    .PWM_DIV    (32'd1000)
  ) dut (
    .tft_clk           (tft_clk),
    .rstb              (rstb),
    .power_req         (power_req),
    .target_duty       (target_duty),
    .new_frame         (new_frame),
    .touch_valid       (touch_valid),
    .touch_x_in        (touch_x_in),
    .touch_y_in        (touch_y_in),
    .tft_vdd_en        (tft_vdd_en),
    .tft_display_en    (tft_display_en),
    .duty_cycle        (duty_cycle),
    .frequency_division(frequency_division),
    .touch_x           (touch_x),
    .touch_y           (touch_y),
    .ready             (ready),
    .state             (state)
  );

  always #5 tft_clk = ~tft_clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: phase, time spent in it, ticks seen in it, duty, touch.
  int m_phase, m_age, m_ticks, m_duty;
  int m_tx, m_ty, m_sx, m_sy;
  bit m_pend, m_nf;

  function automatic int imin(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  task automatic model_reset();
    m_phase = S_OFF; m_age = 0; m_ticks = 0; m_duty = 0;
    m_tx = 240; m_ty = 136; m_sx = 240; m_sy = 136; m_pend = 0; m_nf = 0;
  endtask

  task automatic model_clk();
    bit tick;
    int nxt, tgt;
    if (!rstb) begin
      model_reset();
      return;
    end
    tick = new_frame && !m_nf;
    m_nf = new_frame;
    tgt  = int'(target_duty);
    if (tick && m_pend) begin
      m_tx = m_sx; m_ty = m_sy; m_pend = 0;
    end
    if (touch_valid) begin
      m_sx = imin(int'(touch_x_in), 479);
      m_sy = imin(int'(touch_y_in), 271);
      m_pend = 1;
    end
    nxt = m_phase;
    if (m_phase == S_OFF) begin
      if (power_req) nxt = S_VDD_UP;
    end else if (m_phase == S_VDD_UP) begin
      if (!power_req) nxt = S_OFF;
      else if (m_age + 1 >= VW) nxt = S_DISP_UP;
    end else if (m_phase == S_DISP_UP) begin
      if (!power_req) nxt = S_DISP_DOWN;
      else if (DF == 0 || (tick && m_ticks + 1 >= DF)) nxt = S_RAMP_UP;
      else if (tick) m_ticks++;
    end else if (m_phase == S_RAMP_UP) begin
      if (!power_req) nxt = S_RAMP_DOWN;
      else if (m_duty == tgt) nxt = S_RUN;
      else if (tick) m_duty = imin(m_duty + RS, tgt);
    end else if (m_phase == S_RUN) begin
      if (!power_req) nxt = S_RAMP_DOWN;
      else if (tick) begin
        if (m_duty < tgt) m_duty = m_duty + imin(RS, tgt - m_duty);
        else m_duty = m_duty - imin(RS, m_duty - tgt);
      end
    end else if (m_phase == S_RAMP_DOWN) begin
      if (power_req) nxt = S_RAMP_UP;
      else if (m_duty == 0) nxt = S_DISP_DOWN;
      else if (tick) m_duty = (m_duty > RS) ? m_duty - RS : 0;
    end else begin
      if (m_age + 1 >= VW) nxt = S_OFF;
    end
    if (nxt != m_phase) begin
      m_age = 0; m_ticks = 0;
    end else begin
      m_age++;
    end
    m_phase = nxt;
    if (m_phase == S_OFF || m_phase == S_VDD_UP || m_phase == S_DISP_UP || m_phase == S_DISP_DOWN)
      m_duty = 0;
  endtask

  task automatic check_all();
    check("state",    32'(state),              32'(m_phase));
    check("vdd_en",   32'(tft_vdd_en),         32'(m_phase != S_OFF));
    check("disp_en",  32'(tft_display_en),     32'(m_phase >= S_DISP_UP && m_phase <= S_RAMP_DOWN));
    check("ready",    32'(ready),              32'(m_phase == S_RUN));
    check("duty",     32'(duty_cycle),         32'(m_duty));
    check("freq_div", frequency_division,      32'(PD));
    check("touch_x",  32'(touch_x),            32'(m_tx));
    check("touch_y",  32'(touch_y),            32'(m_ty));
  endtask

  task automatic step();
    @(posedge tft_clk);
    model_clk();
    @(negedge tft_clk);
    check_all();
  endtask

  task automatic frame_tick();
    new_frame = 1'b1;
    step();
    new_frame = 1'b0;
    step();
  endtask

  task automatic power_up_to_ramp(input logic [7:0] tgt);
    target_duty = tgt;
    power_req = 1'b1;
    repeat (VW + 1) step();
    repeat (DF) frame_tick();
    check("bring_up_ramp", 32'(state), 32'(S_RAMP_UP));
  endtask

  task automatic power_down_full();
    power_req = 1'b0;
    for (int i = 0; i < 100 && state != 3'(S_OFF); i++) frame_tick();
    check("power_down_off", 32'(state), 32'(S_OFF));
  endtask

  initial begin
    model_reset();
    repeat (2) @(negedge tft_clk);
    check_all();
    check("reset_touch_x", 32'(touch_x), 32'd240);
    check("reset_touch_y", 32'(touch_y), 32'd136);
    rstb = 1'b1;
    repeat (2) step();

    // Power-up sequence with target 24
    target_duty = 8'd24;
    power_req = 1'b1;
    step();
    check("pu_vdd_on", 32'(tft_vdd_en), 32'd1);
    check("pu_disp_off", 32'(tft_display_en), 32'd0);
    repeat (VW - 1) step();
    check("pu_disp_early", 32'(tft_display_en), 32'd0);
    step();
    check("pu_disp_on", 32'(tft_display_en), 32'd1);
    frame_tick();
    check("pu_hold_disp_up", 32'(state), 32'(S_DISP_UP));
    frame_tick();
    check("pu_ramp_up", 32'(state), 32'(S_RAMP_UP));
    frame_tick();
    check("pu_duty8", 32'(duty_cycle), 32'd8);
    frame_tick();
    check("pu_duty16", 32'(duty_cycle), 32'd16);
    frame_tick();
    check("pu_duty24", 32'(duty_cycle), 32'd24);
    check("pu_ready", 32'(ready), 32'd1);

    // Direction change in RUN
    target_duty = 8'd200;
    for (int i = 0; i < 30 && duty_cycle != 8'd200; i++) frame_tick();
    check("dir_at200", 32'(duty_cycle), 32'd200);
    target_duty = 8'd190;
    frame_tick();
    check("dir_192", 32'(duty_cycle), 32'd192);
    frame_tick();
    check("dir_190", 32'(duty_cycle), 32'd190);

    // Touch released only on frame ticks, clamped
    touch_valid = 1'b1; touch_x_in = 12'd600; touch_y_in = 12'd100;
    step();
    touch_valid = 1'b0;
    repeat (3) step();
    check("touch_hold_x", 32'(touch_x), 32'd240);
    frame_tick();
    check("touch_clamp_x", 32'(touch_x), 32'd479);
    check("touch_y100", 32'(touch_y), 32'd100);
    frame_tick();
    check("touch_nochange_x", 32'(touch_x), 32'd479);
    // Strobe coincident with tick: old shadow out, new one stays pending
    touch_valid = 1'b1; touch_x_in = 12'd10; touch_y_in = 12'd20;
    step();
    touch_valid = 1'b0;
    step();
    touch_valid = 1'b1; touch_x_in = 12'd30; touch_y_in = 12'd4000; new_frame = 1'b1;
    step();
    touch_valid = 1'b0; new_frame = 1'b0;
    step();
    check("touch_win_x", 32'(touch_x), 32'd10);
    check("touch_win_y", 32'(touch_y), 32'd20);
    frame_tick();
    check("touch_pend_x", 32'(touch_x), 32'd30);
    check("touch_pend_y", 32'(touch_y), 32'd271);

    // Abort during ramp-up at duty 16
    power_down_full();
    power_up_to_ramp(8'd100);
    frame_tick();
    frame_tick();
    check("abort_duty16", 32'(duty_cycle), 32'd16);
    power_req = 1'b0;
    step();
    check("abort_ramp_down", 32'(state), 32'(S_RAMP_DOWN));
    frame_tick();
    check("abort_duty8", 32'(duty_cycle), 32'd8);
    frame_tick();
    check("abort_disp_down", 32'(state), 32'(S_DISP_DOWN));
    check("abort_disp_off", 32'(tft_display_en), 32'd0);
    repeat (VW - 1) step();
    check("abort_vdd_still", 32'(tft_vdd_en), 32'd1);
    step();
    check("abort_vdd_off", 32'(tft_vdd_en), 32'd0);

    // Saturation near 255
    power_up_to_ramp(8'd250);
    for (int i = 0; i < 40 && duty_cycle != 8'd248; i++) frame_tick();
    check("sat_at248", 32'(duty_cycle), 32'd248);
    frame_tick();
    check("sat_duty250", 32'(duty_cycle), 32'd250);
    check("sat_run", 32'(state), 32'(S_RUN));

    // Asynchronous reset mid-cycle in RUN
    #2;
    rstb = 1'b0;
    #1;
    check("areset_state", 32'(state), 32'(S_OFF));
    check("areset_vdd", 32'(tft_vdd_en), 32'd0);
    check("areset_duty", 32'(duty_cycle), 32'd0);
    check("areset_ready", 32'(ready), 32'd0);
    check("areset_tx", 32'(touch_x), 32'd240);
    @(negedge tft_clk);
    model_reset();
    check_all();
    rstb = 1'b1;

    // Randomized run
    for (int c = 0; c < 4000; c++) begin
      if ($urandom_range(0, 59) == 0) power_req = ~power_req;
      if ($urandom_range(0, 79) == 0) begin
        case ($urandom_range(0, 3))
          0: target_duty = 8'd0;
          1: target_duty = 8'd255;
          default: target_duty = 8'($urandom_range(0, 255));
        endcase
      end
      new_frame   = ($urandom_range(0, 4) == 0);
      touch_valid = ($urandom_range(0, 15) == 0);
      touch_x_in  = 12'($urandom_range(0, 4095));
      touch_y_in  = 12'($urandom_range(0, 4095));
      rstb        = ($urandom_range(0, 999) != 0);
      step();
    end
    rstb = 1'b1;
    step();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
